// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: glyph table and off levels.
// Reused by every seg7 block in the display subsystem.
package seg7_pkg;

    // Active-high {a,b,c,d,e,f,g,dp} glyphs, entry n = hex digit n
    localparam logic [15:0][7:0] GLYPH_TBL = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C,
        8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66,
        8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    localparam logic [7:0] SEG_OFF_AL = 8'hFF;
    localparam logic [7:0] SEG_OFF_AH = 8'h00;

    function automatic logic [7:0] seg_off(input logic al);
        return al ? SEG_OFF_AL : SEG_OFF_AH;
    endfunction

endpackage

// File: rtl/seg7_scan_drv_if.sv
// Host-side bus of the multiplexed seven-segment scanner.
// master = controller driving data, slave = the scanner.
interface seg7_scan_drv_if #(
    parameter int NDIGIT = 8
);
    logic                  en;
    logic                  load;
    logic [4*NDIGIT-1:0]   value;
    logic [NDIGIT-1:0]     dp;
    logic                  lz_en;
    logic [7:0]            seg;
    logic [NDIGIT-1:0]     an;
    logic                  frame_done;

    modport master (
        output en, load, value, dp, lz_en,
        input  seg, an, frame_done
    );

    modport slave (
        input  en, load, value, dp, lz_en,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seg7_decode.sv
// Hex nibble to active-high {a..g} segment pattern.
// Purely combinational lookup into the shared glyph table.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    logic [7:0] glyph;

    assign glyph = GLYPH_TBL[nib_i];
    assign seg_o = glyph[7:1];
endmodule

// File: rtl/seg7_scan_drv.sv
// Time-multiplexed seven-segment scanner with double-buffered
// display data, leading-zero blanking and frame pulse.
module seg7_scan_drv
    import seg7_pkg::*;
#(
    parameter int NDIGIT     = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input logic           clk,
    input logic           rst_n,
    seg7_scan_drv_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NDIGIT);
    localparam int VW = 4 * NDIGIT;

    localparam logic [PW-1:0] P_TC   = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NDIGIT - 1);

    localparam logic              AL      = (ACTIVE_LOW != 0);
    localparam logic [7:0]        SEG_OFF = seg_off(AL);
    localparam logic [NDIGIT-1:0] AN_OFF  = {NDIGIT{AL}};

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              run_q, run_d;
    logic [VW-1:0]     sh_val_q, sh_val_d;
    logic [NDIGIT-1:0] sh_dp_q, sh_dp_d;
    logic              sh_lz_q, sh_lz_d;
    logic [VW-1:0]     dv_val_q, dv_val_d;
    logic [NDIGIT-1:0] dv_dp_q, dv_dp_d;
    logic              dv_lz_q, dv_lz_d;
    logic [7:0]        seg_q, seg_d;
    logic [NDIGIT-1:0] an_q, an_d;
    logic              fd_q, fd_d;

    logic              tc, last, wrap;
    logic [3:0]        nib;
    logic [6:0]        glyph;
    logic [VW-1:0]     upper;
    logic              blank;

    assign tc   = (presc_q == P_TC);
    assign last = (idx_q == I_LAST);
    assign wrap = bus.en & run_q & tc & last;

    always_comb begin
        presc_d  = presc_q;
        idx_d    = idx_q;
        run_d    = run_q;
        sh_val_d = sh_val_q;
        sh_dp_d  = sh_dp_q;
        sh_lz_d  = sh_lz_q;
        dv_val_d = dv_val_q;
        dv_dp_d  = dv_dp_q;
        dv_lz_d  = dv_lz_q;

        if (bus.load) begin
            sh_val_d = bus.value;
            sh_dp_d  = bus.dp;
            sh_lz_d  = bus.lz_en;
        end

        // First enabled edge lights digit 0 with a fresh full period
        if (!bus.en) begin
            run_d   = 1'b0;
            presc_d = '0;
            idx_d   = '0;
        end else if (!run_q) begin
            run_d   = 1'b1;
            presc_d = '0;
            idx_d   = '0;
        end else if (tc) begin
            presc_d = '0;
            idx_d   = last ? '0 : idx_q + IW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (wrap) begin
            dv_val_d = sh_val_q;
            dv_dp_d  = sh_dp_q;
            dv_lz_d  = sh_lz_q;
        end
    end

    assign nib   = dv_val_d[{idx_d, 2'b00} +: 4];
    assign upper = dv_val_d >> {idx_d, 2'b00};
    assign blank = dv_lz_d && (idx_d != '0) && (upper == '0);

    seg7_decode u_dec (
        .nib_i (nib),
        .seg_o (glyph)
    );

    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        fd_d  = wrap;
        if (bus.en) begin
            seg_d = {blank ? 7'h00 : glyph, dv_dp_d[idx_d]} ^ {8{AL}};
            an_d  = (NDIGIT'(1) << idx_d) ^ AN_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q  <= '0;
            idx_q    <= '0;
            run_q    <= 1'b0;
            sh_val_q <= '0;
            sh_dp_q  <= '0;
            sh_lz_q  <= 1'b0;
            dv_val_q <= '0;
            dv_dp_q  <= '0;
            dv_lz_q  <= 1'b0;
            seg_q    <= SEG_OFF;
            an_q     <= AN_OFF;
            fd_q     <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            run_q    <= run_d;
            sh_val_q <= sh_val_d;
            sh_dp_q  <= sh_dp_d;
            sh_lz_q  <= sh_lz_d;
            dv_val_q <= dv_val_d;
            dv_dp_q  <= dv_dp_d;
            dv_lz_q  <= dv_lz_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            fd_q     <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_drv.sv
// Bench for seg7_scan_drv: 4 digits, 4-cycle scan, active-low.
// Directed table, corner sequences and a random run vs a reference model.
module tb_seg7_scan_drv;
    localparam int ND = 4;
    localparam int SD = 4;
    localparam int FRAME = ND * SD;

    logic clk = 1'b0;
    logic rst_n;

    seg7_scan_drv_if #(.NDIGIT(ND)) ifc ();

    seg7_scan_drv #(
        .NDIGIT     (ND),
        .SCAN_DIV   (SD),
        .ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] gl [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    // Reference state: mk = edges since scanning began, -1 = dark
    int          mk;
    logic [15:0] msv, mdv;
    logic [3:0]  msd, mdd;
    logic        msl, mdl;
    logic [7:0]  es;
    logic [3:0]  ea;
    logic        ef;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_seg(input logic [15:0] v,
                                           input logic [3:0] d,
                                           input logic lz,
                                           input int dig);
        logic [15:0] hi;
        logic [7:0]  g;
        hi = v >> (4 * dig);
        g  = (lz && dig > 0 && hi == 16'h0) ? 8'h00 : gl[hi[3:0]];
        g[0] = d[dig];
        return ~g;
    endfunction

    task automatic cyc();
        logic       wrap;
        logic [3:0] one;
        int         dig;
        one = 4'b0001;
        if (!rst_n) begin
            mk = -1;
            msv = '0; msd = '0; msl = 1'b0;
            mdv = '0; mdd = '0; mdl = 1'b0;
            es = 8'hFF; ea = 4'hF; ef = 1'b0;
        end else begin
            wrap = ifc.en && mk >= 0 && ((mk + 1) % FRAME == 0);
            if (wrap) begin
                mdv = msv; mdd = msd; mdl = msl;
            end
            if (ifc.load) begin
                msv = ifc.value; msd = ifc.dp; msl = ifc.lz_en;
            end
            if (ifc.en) begin
                mk++;
                dig = (mk / SD) % ND;
                es = ref_seg(mdv, mdd, mdl, dig);
                ea = ~(one << dig);
                ef = wrap;
            end else begin
                mk = -1;
                es = 8'hFF; ea = 4'hF; ef = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("model", {19'h0, ifc.seg, ifc.an, ifc.frame_done},
            {19'h0, es, ea, ef});
    endtask

    task automatic wait_fd(input int budget);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!ifc.frame_done && n < budget);
        chk("fd_wait", {31'h0, ifc.frame_done}, 32'h1);
    endtask

    task automatic wait_an(input logic [3:0] tgt, input int budget);
        int n;
        n = 0;
        while (ifc.an !== tgt && n < budget) begin
            cyc();
            n++;
        end
        chk("an_wait", {28'h0, ifc.an}, {28'h0, tgt});
    endtask

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic            lz;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t tv [6];

    initial begin
        int fd_cnt;
        int fd_pos [$];

        tv[0] = '{16'h12AF, 4'b0000, 1'b0, {8'h9F, 8'h25, 8'h11, 8'h71}};
        tv[1] = '{16'h0005, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h49}};
        tv[2] = '{16'h0005, 4'b0000, 1'b0, {8'h03, 8'h03, 8'h03, 8'h49}};
        tv[3] = '{16'h0005, 4'b0100, 1'b1, {8'hFF, 8'hFE, 8'hFF, 8'h49}};
        tv[4] = '{16'h0300, 4'b0000, 1'b1, {8'hFF, 8'h0D, 8'h03, 8'h03}};
        tv[5] = '{16'hF00E, 4'b0001, 1'b1, {8'h71, 8'h03, 8'h03, 8'h60}};

        rst_n = 1'b0;
        ifc.en = 1'b0; ifc.load = 1'b0;
        ifc.value = '0; ifc.dp = '0; ifc.lz_en = 1'b0;
        @(negedge clk);
        cyc();
        cyc();
        chk("reset_seg", {24'h0, ifc.seg}, 32'hFF);
        chk("reset_an", {28'h0, ifc.an}, 32'hF);

        rst_n = 1'b1;
        ifc.en = 1'b1;
        cyc();
        chk("start_d0", {20'h0, ifc.seg, ifc.an}, {20'h0, 8'h03, 4'hE});

        // Directed glyph / blanking table
        for (int i = 0; i < 6; i++) begin
            ifc.value = tv[i].value;
            ifc.dp    = tv[i].dp;
            ifc.lz_en = tv[i].lz;
            ifc.load  = 1'b1;
            cyc();
            ifc.load  = 1'b0;
            wait_fd(2 * FRAME + 2);
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("tbl%0d_d%0d", i, d),
                    {20'h0, ifc.seg, ifc.an},
                    {20'h0, tv[i].exp[d], ~(4'b0001 << d)});
                repeat (SD) cyc();
            end
        end

        // New data mid-frame must not tear the current frame
        ifc.value = 16'h1111; ifc.dp = '0; ifc.lz_en = 1'b0;
        ifc.load = 1'b1;
        cyc();
        ifc.load = 1'b0;
        wait_fd(2 * FRAME + 2);
        repeat (6) cyc();
        ifc.value = 16'h2222;
        ifc.load = 1'b1;
        cyc();
        ifc.load = 1'b0;
        for (int n = 0; n < FRAME && !ifc.frame_done; n++) begin
            chk("tear_old", {24'h0, ifc.seg}, 32'h9F);
            cyc();
        end
        chk("tear_wrap", {31'h0, ifc.frame_done}, 32'h1);
        for (int n = 0; n < FRAME; n++) begin
            chk("tear_new", {24'h0, ifc.seg}, 32'h25);
            cyc();
        end

        // Three frames -> three single-cycle pulses, 16 apart
        wait_fd(2 * FRAME);
        fd_cnt = 0;
        for (int c = 1; c <= 3 * FRAME; c++) begin
            cyc();
            if (ifc.frame_done) begin
                fd_cnt++;
                fd_pos.push_back(c);
            end
        end
        chk("fd_count", fd_cnt, 3);
        chk("fd_pos0", fd_pos.size() > 0 ? fd_pos[0] : -1, FRAME);
        chk("fd_pos2", fd_pos.size() > 2 ? fd_pos[2] : -1, 3 * FRAME);

        // Disable mid-frame then re-enable
        repeat (5) cyc();
        ifc.en = 1'b0;
        cyc();
        chk("dis_off", {20'h0, ifc.seg, ifc.an}, {20'h0, 8'hFF, 4'hF});
        cyc();
        ifc.en = 1'b1;
        for (int n = 0; n < SD; n++) begin
            cyc();
            chk("reen_d0", {28'h0, ifc.an}, 32'hE);
        end
        cyc();
        chk("reen_d1", {28'h0, ifc.an}, 32'hD);

        // Reset at digit 2 aborts the frame
        wait_an(4'b1011, 2 * FRAME);
        rst_n = 1'b0;
        cyc();
        chk("rst_off", {19'h0, ifc.seg, ifc.an, ifc.frame_done},
            {19'h0, 8'hFF, 4'hF, 1'b0});
        rst_n = 1'b1;
        cyc();
        chk("rst_d0", {20'h0, ifc.seg, ifc.an}, {20'h0, 8'h03, 4'hE});
        for (int n = 0; n < FRAME - 1; n++) begin
            cyc();
            chk("rst_nofd", {31'h0, ifc.frame_done}, 32'h0);
        end

        // Random traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            ifc.load = ($urandom_range(0, 7) == 0);
            if (ifc.load) begin
                ifc.value = 16'($urandom);
                ifc.dp    = 4'($urandom);
                ifc.lz_en = 1'($urandom);
                if ($urandom_range(0, 3) == 0)
                    ifc.value = ifc.value & 16'h00FF;
            end
            if ($urandom_range(0, 59) == 0)
                ifc.en = ~ifc.en;
            else if (!ifc.en && $urandom_range(0, 4) == 0)
                ifc.en = 1'b1;
            rst_n = ($urandom_range(0, 399) != 0);
            cyc();
        end
        ifc.load = 1'b0;
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_drv.md
SEG7_SCAN_DRV -- requirements
Module: seg7_scan_drv

Interface
REQ-001 Parameter NDIGIT, default 8: number of multiplexed digits, range 2..16.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles each digit is lit, minimum 2.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 drives seg/an inverted (lit = 0); 0 drives them true (lit = 1).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 en  input  1  1 = scanning; 0 = display dark.
REQ-007 load  input  1  one-cycle strobe; captures value/dp/lz_en into the shadow registers.
REQ-008 value  input  4*NDIGIT  hex nibbles; nibble i drives digit i (digit 0 = LSB, rightmost).
REQ-009 dp  input  NDIGIT  decimal-point request per digit.
REQ-010 lz_en  input  1  1 = leading-zero blanking enabled.
REQ-011 seg  output  8  registered segments {a,b,c,d,e,f,g,dp}; seg[7] = a, seg[0] = dp.
REQ-012 an  output  NDIGIT  registered one-hot digit select.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each full scan frame.

Function
REQ-014 The prescaler counts 0..SCAN_DIV-1 while en=1; at terminal count it wraps to 0 and advances the digit index.
REQ-015 The digit index counts 0..NDIGIT-1 and wraps from NDIGIT-1 to 0.
REQ-016 seg and an shall change one cycle after the prescaler terminal count, so each digit is lit for exactly SCAN_DIV cycles.
REQ-017 load=1 copies value, dp and lz_en into the shadow registers on the next edge; the displayed copy updates from the shadow only when the index wraps to 0, so no frame mixes old and new data.
REQ-018 When load coincides with a frame wrap, the newly loaded data takes effect at the next wrap.
REQ-019 Active-high glyphs {a..g,0} shall be: 0:FC 1:60 2:DA 3:F2 4:66 5:B6 6:BE 7:E0 8:FE 9:F6 A:EE b:3E C:9C d:7A E:9E F:8E.
REQ-020 The seg dp bit shall equal the displayed dp bit of the current digit, ORed onto the glyph.
REQ-021 With lz_en=1, digit i>0 is blanked (glyph 00) when nibbles i..NDIGIT-1 are all zero; digit 0 is never blanked; dp is still shown on a blanked digit.
REQ-022 frame_done pulses for one cycle when the index wraps from NDIGIT-1 to 0.
REQ-023 en=0 shall clear the prescaler and index to 0 and drive seg/an to the off level on the next edge; shadow registers keep their contents and load is still accepted.
REQ-024 On en rising, digit 0 lights on the next edge with the current displayed data and runs a full SCAN_DIV period.
REQ-025 ACTIVE_LOW inverts seg and an at the output registers only; internal logic is polarity-independent.

Reset
REQ-026 When rst_n=0 at an edge: prescaler=0, index=0, shadow and displayed registers=0, seg=off, an=off, frame_done=0.
REQ-027 Reset asserted mid-frame aborts the frame without a frame_done pulse; scanning restarts at digit 0 on the first edge with rst_n=1 and en=1.

Structure
REQ-028 The glyph table and off-level constants shall live in the shared package seg7_pkg, which other seg7 blocks reuse.
REQ-029 Nibble-to-glyph decoding shall be one combinational sub-module, seg7_decode (4-bit in, 7-bit active-high out), instanced once on the selected nibble.
REQ-030 The prescaler width shall be $clog2(SCAN_DIV) and the index width $clog2(NDIGIT).

Verification
REQ-031 NDIGIT=4, SCAN_DIV=4, ACTIVE_LOW=1; load value=16'h12AF, dp=0, lz_en=0 -> after the frame wrap, an cycles 1110,1101,1011,0111, each for 4 cycles, with seg = ~8'h8E, ~8'hEE, ~8'hDA, ~8'h60.
REQ-032 load value=16'h0005, lz_en=1 -> digits 3..1 show seg=8'hFF (blank), digit 0 shows ~8'hB6; with lz_en=0, digits 3..1 show ~8'hFC.
REQ-033 Load 16'h1111 and then 16'h2222 in the middle of a frame -> the current frame shows all 1s; the next frame shows all 2s; no frame mixes the two values.
REQ-034 Run 3 frames -> frame_done pulses exactly 3 times, 16 cycles apart, each for 1 cycle.
REQ-035 en=0 mid-frame -> seg=8'hFF and an=4'hF on the next edge; en=1 -> an=1110 on the next edge, lasting 4 cycles.
REQ-036 rst_n=0 at digit 2 -> outputs off and no frame_done; after release, digit 0 shows ~8'hFC (value 0).
